// File: rtl/nios_sram_pkg.sv
// Shared definitions for the Nios SRAM address generator: register offsets,
// CTRL bit positions and the end-of-range behaviour selector.
package nios_sram_pkg;

    localparam logic [1:0] REG_CUR    = 2'd0;
    localparam logic [1:0] REG_LIMIT  = 2'd1;
    localparam logic [1:0] REG_STRIDE = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_FLAG   = 8;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_STOP = 1'b1
    } mode_e;

endpackage

// File: rtl/nios_system_sram_addr_gen_if.sv
// Avalon-MM slave bus plus the stepping/address/interrupt side signals of the
// SRAM address generator, bundled so CPU-side and SRAM-side wiring travel together.
interface nios_system_sram_addr_gen_if #(
    parameter int ADDR_W = 11
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              advance;
    logic [ADDR_W-1:0] out_port;
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata, advance,
        input  readdata, out_port, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata, advance,
        output readdata, out_port, irq
    );
endinterface

// File: rtl/nios_addr_stepper.sv
// Holds the current and base address and performs one stride step per request,
// detecting overrun of the limit on a widened sum so nothing wraps silently.
module nios_addr_stepper
    import nios_sram_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int STRIDE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [ADDR_W-1:0]   i_load_val,
    input  logic                i_step,
    input  logic [STRIDE_W-1:0] i_stride,
    input  logic [ADDR_W-1:0]   i_limit,
    input  mode_e               i_mode,
    output logic [ADDR_W-1:0]   o_cur,
    output logic                o_overflow
);

    // One extra bit beyond the wider operand keeps the carry visible to the compare.
    localparam int SUM_W = ((ADDR_W > STRIDE_W) ? ADDR_W : STRIDE_W) + 1;

    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_base;
    logic [SUM_W-1:0]  w_sum;
    logic              w_beyond;

    assign w_sum      = SUM_W'(r_cur) + SUM_W'(i_stride);
    assign w_beyond   = w_sum > SUM_W'(i_limit);
    assign o_overflow = i_step & w_beyond;
    assign o_cur      = r_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur  <= '0;
            r_base <= '0;
        end else if (i_load) begin
            r_cur  <= i_load_val;
            r_base <= i_load_val;
        end else if (i_step) begin
            if (!w_beyond) begin
                r_cur <= w_sum[ADDR_W-1:0];
            end else if (i_mode == MODE_WRAP) begin
                r_cur <= r_base;
            end
        end
    end

endmodule

// File: rtl/nios_system_sram_addr_gen.sv
// Avalon-MM programmable SRAM address generator: bus register file and CTRL/flag
// handling here, address arithmetic in nios_addr_stepper.
module nios_system_sram_addr_gen
    import nios_sram_pkg::*;
#(
    parameter int                ADDR_W      = 11,
    parameter int                STRIDE_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_LIMIT = {ADDR_W{1'b1}}
) (
    input  logic                         clk,
    input  logic                         reset,
    nios_system_sram_addr_gen_if.slave   bus
);

    logic [ADDR_W-1:0]   r_limit;
    logic [STRIDE_W-1:0] r_stride;
    logic                r_enable;
    mode_e               r_mode;
    logic                r_irq_en;
    logic                r_flag;

    logic              w_wr;
    logic              w_wr_cur;
    logic              w_wr_ctrl;
    logic              w_step;
    logic              w_overflow;
    logic [ADDR_W-1:0] w_cur;
    logic [31:0]       w_ctrl;
    logic              w_unused_wd;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wr_cur    = w_wr && (bus.address == REG_CUR);
    assign w_wr_ctrl   = w_wr && (bus.address == REG_CTRL);
    // Enable is sampled before any CTRL write lands, and a CUR write pre-empts stepping.
    assign w_step      = bus.advance & r_enable & ~w_wr_cur;
    assign w_unused_wd = ^bus.writedata;

    nios_addr_stepper #(
        .ADDR_W   (ADDR_W),
        .STRIDE_W (STRIDE_W)
    ) u_stepper (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_wr_cur),
        .i_load_val (bus.writedata[ADDR_W-1:0]),
        .i_step     (w_step),
        .i_stride   (r_stride),
        .i_limit    (r_limit),
        .i_mode     (r_mode),
        .o_cur      (w_cur),
        .o_overflow (w_overflow)
    );

    // Hardware overflow is applied last so it beats a same-cycle software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_limit  <= RESET_LIMIT;
            r_stride <= STRIDE_W'(1);
            r_enable <= 1'b0;
            r_mode   <= MODE_WRAP;
            r_irq_en <= 1'b0;
            r_flag   <= 1'b0;
        end else begin
            if (w_wr && bus.address == REG_LIMIT) begin
                r_limit <= bus.writedata[ADDR_W-1:0];
            end
            if (w_wr && bus.address == REG_STRIDE) begin
                r_stride <= bus.writedata[STRIDE_W-1:0];
            end
            if (w_wr_cur) begin
                r_flag <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_enable <= bus.writedata[CTRL_ENABLE];
                r_mode   <= mode_e'(bus.writedata[CTRL_MODE]);
                r_irq_en <= bus.writedata[CTRL_IRQ_EN];
                if (bus.writedata[CTRL_FLAG]) begin
                    r_flag <= 1'b0;
                end
            end
            if (w_overflow) begin
                r_flag <= 1'b1;
                if (r_mode == MODE_STOP) begin
                    r_enable <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_ctrl              = '0;
        w_ctrl[CTRL_ENABLE] = r_enable;
        w_ctrl[CTRL_MODE]   = r_mode;
        w_ctrl[CTRL_IRQ_EN] = r_irq_en;
        w_ctrl[CTRL_FLAG]   = r_flag;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            REG_CUR:    bus.readdata = 32'(w_cur);
            REG_LIMIT:  bus.readdata = 32'(r_limit);
            REG_STRIDE: bus.readdata = 32'(r_stride);
            default:    bus.readdata = w_ctrl;
        endcase
    end

    assign bus.out_port = w_cur;
    assign bus.irq      = r_flag & r_irq_en;

endmodule

// File: tb/tb_nios_system_sram_addr_gen.sv
// Directed scenario tasks plus a randomized run scored against a plain-arithmetic
// model of the address generator's register-level behaviour.
module tb_nios_system_sram_addr_gen;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // Reference model state (plain integers)
    int mCur, mBase, mLimit, mStride, mEn, mMode, mIrqEn, mFlag;

    nios_system_sram_addr_gen_if #(.ADDR_W(11)) bus ();

    nios_system_sram_addr_gen #(
        .ADDR_W   (11),
        .STRIDE_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idleBus();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'd0;
        bus.advance    = 1'b0;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        idleBus();
    endtask

    task automatic writeWithAdvance(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        bus.advance    = 1'b1;
        @(negedge clk);
        idleBus();
    endtask

    task automatic busRead(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic pulseAdvance();
        @(negedge clk);
        bus.advance = 1'b1;
        @(negedge clk);
        bus.advance = 1'b0;
    endtask

    task automatic modelReset();
        mCur = 0; mBase = 0; mLimit = 'h7FF; mStride = 1;
        mEn = 0; mMode = 0; mIrqEn = 0; mFlag = 0;
    endtask

    // One clock of the register-level behaviour, from the programmer's view
    task automatic modelClock(input bit wr, input int a, input int d, input bit adv);
        bit doStep;
        int sum, oldLimit, oldMode;
        doStep   = adv && (mEn != 0) && !(wr && a == 0);
        sum      = mCur + mStride;
        oldLimit = mLimit;
        oldMode  = mMode;
        if (wr) begin
            case (a)
                0: begin mCur = d & 'h7FF; mBase = d & 'h7FF; mFlag = 0; end
                1: mLimit = d & 'h7FF;
                2: mStride = d & 'hFF;
                default: begin
                    mEn = d & 1; mMode = (d >> 1) & 1; mIrqEn = (d >> 2) & 1;
                    if (((d >> 8) & 1) != 0) mFlag = 0;
                end
            endcase
        end
        if (doStep) begin
            if (sum <= oldLimit) mCur = sum;
            else begin
                mFlag = 1;
                if (oldMode == 0) mCur = mBase;
                else mEn = 0;
            end
        end
    endtask

    function automatic int modelRead(input int a);
        case (a)
            0: return mCur;
            1: return mLimit;
            2: return mStride;
            default: return mEn | (mMode << 1) | (mIrqEn << 2) | (mFlag << 8);
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        idleBus();
        repeat (2) @(negedge clk);
        total++; if (bus.out_port !== 11'h000) begin bad++; $display("[TB] FAIL reset_out_port got=%h exp=000", bus.out_port); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b exp=0", bus.irq); end
        reset = 1'b0;
        busRead(2'd1, rd);
        total++; if (rd !== 32'h7FF) begin bad++; $display("[TB] FAIL reset_limit got=%h exp=7ff", rd); end
        busRead(2'd2, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL reset_stride got=%h exp=1", rd); end
        busRead(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_ctrl got=%h exp=0", rd); end
        // Build up state mid-count with a pending interrupt, then reset between edges
        busWrite(2'd0, 32'h15);
        busWrite(2'd1, 32'h15);
        busWrite(2'd3, 32'h5);
        pulseAdvance();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_irq got=%b exp=1", bus.irq); end
        total++; if (bus.out_port !== 11'h015) begin bad++; $display("[TB] FAIL pre_reset_cur got=%h exp=015", bus.out_port); end
        #2;
        bus.address = 2'd3;
        reset = 1'b1;
        #1;
        total++; if (bus.out_port !== 11'h000) begin bad++; $display("[TB] FAIL async_reset_out_port got=%h exp=000", bus.out_port); end
        total++; if (bus.readdata !== 32'h0) begin bad++; $display("[TB] FAIL async_reset_ctrl got=%h exp=0", bus.readdata); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_irq got=%b exp=0", bus.irq); end
        @(negedge clk);
        reset = 1'b0;
        idleBus();
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int expSeq[4] = '{'h14, 'h18, 'h1C, 'h10};
        busWrite(2'd0, 32'h10);
        busWrite(2'd2, 32'h4);
        busWrite(2'd1, 32'h1C);
        busWrite(2'd3, 32'h1);
        for (int i = 0; i < 4; i++) begin
            pulseAdvance();
            total++; if (bus.out_port !== 11'(expSeq[i])) begin bad++; $display("[TB] FAIL wrap_step%0d got=%h exp=%h", i, bus.out_port, expSeq[i]); end
        end
        busRead(2'd3, rd);
        total++; if (rd !== 32'h101) begin bad++; $display("[TB] FAIL wrap_ctrl got=%h exp=101", rd); end
    endtask

    task automatic test_stop();
        logic [31:0] rd;
        int expSeq[5] = '{'h14, 'h18, 'h1C, 'h1C, 'h1C};
        busWrite(2'd0, 32'h10);
        busWrite(2'd3, 32'h3);
        for (int i = 0; i < 5; i++) begin
            pulseAdvance();
            total++; if (bus.out_port !== 11'(expSeq[i])) begin bad++; $display("[TB] FAIL stop_step%0d got=%h exp=%h", i, bus.out_port, expSeq[i]); end
        end
        busRead(2'd3, rd);
        total++; if (rd !== 32'h102) begin bad++; $display("[TB] FAIL stop_ctrl got=%h exp=102", rd); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_masked got=%b exp=0", bus.irq); end
        busWrite(2'd3, 32'h6);
        total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_enabled got=%b exp=1", bus.irq); end
        busWrite(2'd3, 32'h106);
        total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_cleared got=%b exp=0", bus.irq); end
        busWrite(2'd3, 32'h5);
        busWrite(2'd0, 32'h1C);
        writeWithAdvance(2'd3, 32'h105);
        total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set_beats_clear got=%b exp=1", bus.irq); end
        total++; if (bus.out_port !== 11'h01C) begin bad++; $display("[TB] FAIL irq_wrap_cur got=%h exp=01c", bus.out_port); end
        busRead(2'd3, rd);
        total++; if (rd !== 32'h105) begin bad++; $display("[TB] FAIL irq_ctrl got=%h exp=105", rd); end
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        writeWithAdvance(2'd0, 32'h40);
        total++; if (bus.out_port !== 11'h040) begin bad++; $display("[TB] FAIL cur_write_wins got=%h exp=040", bus.out_port); end
        busRead(2'd3, rd);
        total++; if (rd !== 32'h5) begin bad++; $display("[TB] FAIL cur_write_clears_flag got=%h exp=5", rd); end
        busWrite(2'd3, 32'h0);
        writeWithAdvance(2'd3, 32'h1);
        total++; if (bus.out_port !== 11'h040) begin bad++; $display("[TB] FAIL enable_presample got=%h exp=040", bus.out_port); end
        busWrite(2'd1, 32'h7FF);
        writeWithAdvance(2'd2, 32'h10);
        total++; if (bus.out_port !== 11'h044) begin bad++; $display("[TB] FAIL old_stride_used got=%h exp=044", bus.out_port); end
        pulseAdvance();
        total++; if (bus.out_port !== 11'h054) begin bad++; $display("[TB] FAIL new_stride_used got=%h exp=054", bus.out_port); end
        busWrite(2'd2, 32'h8);
        busWrite(2'd0, 32'h7FC);
        pulseAdvance();
        total++; if (bus.out_port !== 11'h7FC) begin bad++; $display("[TB] FAIL top_edge_wrap got=%h exp=7fc", bus.out_port); end
        busRead(2'd3, rd);
        total++; if (rd !== 32'h101) begin bad++; $display("[TB] FAIL top_edge_flag got=%h exp=101", rd); end
    endtask

    task automatic test_stride_zero();
        logic [31:0] rd;
        busWrite(2'd2, 32'h0);
        busWrite(2'd0, 32'h20);
        busWrite(2'd3, 32'h1);
        @(negedge clk);
        bus.advance = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++; if (bus.out_port !== 11'h020) begin bad++; $display("[TB] FAIL stride0_hold%0d got=%h exp=020", i, bus.out_port); end
        end
        bus.advance = 1'b0;
        busRead(2'd3, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL stride0_noflag got=%h exp=1", rd); end
    endtask

    task automatic test_random();
        int a, d, ra, expRd;
        bit wr, adv;
        @(negedge clk);
        reset = 1'b1;
        idleBus();
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            total++; if (bus.out_port !== 11'(mCur)) begin bad++; $display("[TB] FAIL rand_out_port it=%0d got=%h exp=%h", i, bus.out_port, mCur); end
            total++; if (bus.irq !== 1'(mFlag & mIrqEn)) begin bad++; $display("[TB] FAIL rand_irq it=%0d got=%b exp=%0d", i, bus.irq, mFlag & mIrqEn); end
            ra = $urandom_range(0, 3);
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            bus.advance    = 1'b0;
            bus.address    = 2'(ra);
            #1;
            expRd = modelRead(ra);
            total++; if (bus.readdata !== 32'(expRd)) begin bad++; $display("[TB] FAIL rand_read it=%0d reg=%0d got=%h exp=%h", i, ra, bus.readdata, expRd); end
            wr  = ($urandom_range(0, 3) == 0);
            adv = ($urandom_range(0, 2) != 0);
            a   = $urandom_range(0, 3);
            case (a)
                0: d = $urandom_range(0, 'h7FF);
                1: d = $urandom_range('h100, 'h7FF);
                2: d = $urandom_range(0, 'h40);
                default: d = int'($urandom_range(0, 3) != 0) | ($urandom_range(0, 1) << 1)
                           | ($urandom_range(0, 1) << 2) | (int'($urandom_range(0, 3) == 0) << 8);
            endcase
            bus.chipselect = wr;
            bus.write_n    = ~wr;
            bus.address    = 2'(a);
            bus.writedata  = 32'(d);
            bus.advance    = adv;
            @(posedge clk);
            modelClock(wr, a, d, adv);
        end
        @(negedge clk);
        idleBus();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idleBus();
        modelReset();
        test_reset();
        test_wrap();
        test_stop();
        test_irq();
        test_collision();
        test_stride_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
